// File: rtl/clock_sched_pkg.sv
// Shared definitions for the slot scheduler and its round-robin arbiter:
// state encoding, default sizes and the rotating-priority search helper.
package clock_sched_pkg;

   localparam int N_REQ_DEF    = 4;
   localparam int ID_W_DEF     = 2;
   localparam int PERIOD_W_DEF = 8;

   // Widest requester set the helper can search; narrower sets are zero-padded.
   localparam int MAX_REQ = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_result_t;

   // Search ptr+1, ptr+2, ... modulo n and return the first index with req set.
   function automatic rr_result_t next_rr(input logic [MAX_REQ-1:0] req,
                                          input logic [2:0]         ptr,
                                          input int unsigned        n);
      rr_result_t  res;
      int unsigned k;
      res = '0;
      for (int unsigned i = 1; i <= MAX_REQ; i++) begin
         k = (32'(ptr) + i) % n;
         if (i <= n && !res.found && req[3'(k)]) begin
            res.found = 1'b1;
            res.idx   = 3'(k);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/clock_slot_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter: the requester after ptr wins first.
module rr_arbiter
   import clock_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int ID_W  = ID_W_DEF
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             found,
   output logic [ID_W-1:0]  idx,
   output logic [N_REQ-1:0] onehot
);

   rr_result_t w_res;

   // Widen to the helper's fixed search width and pick the winner.
   always_comb begin
      w_res = next_rr(MAX_REQ'(req), 3'(ptr), N_REQ);
      found = w_res.found;
      idx   = ID_W'(w_res.idx);
   end

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign onehot[gi] = found && (idx == ID_W'(gi));
   end

endmodule

// File: rtl/clock_slot_scheduler.sv
// Divides clock into periodic slot ticks and grants each slot round-robin.
// Grants are one-cycle clock-enable pulses aligned with tick; no derived clocks.
module clock_slot_scheduler
   import clock_sched_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int ID_W     = ID_W_DEF,
   parameter int PERIOD_W = PERIOD_W_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                run,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic                period_load,
   input  logic [N_REQ-1:0]    req,
   output logic                tick,
   output logic [N_REQ-1:0]    grant,
   output logic [ID_W-1:0]     grant_id,
   output logic                busy
);

   state_t              r_state;
   logic [PERIOD_W-1:0] r_count;
   logic [PERIOD_W-1:0] r_period;
   logic [ID_W-1:0]     r_rr_ptr;
   logic                r_tick;
   logic [N_REQ-1:0]    r_grant;
   logic [ID_W-1:0]     r_grant_id;

   state_t              w_state_next;
   logic [PERIOD_W-1:0] w_count_next;
   logic [PERIOD_W-1:0] w_period_eff;
   logic [ID_W-1:0]     w_rr_ptr_next;
   logic                w_tick_next;
   logic [N_REQ-1:0]    w_grant_next;
   logic [ID_W-1:0]     w_grant_id_next;

   logic                w_found;
   logic [ID_W-1:0]     w_idx;
   logic [N_REQ-1:0]    w_onehot;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req    (req),
      .ptr    (r_rr_ptr),
      .found  (w_found),
      .idx    (w_idx),
      .onehot (w_onehot)
   );

   // Period seen by a reload this cycle: a same-cycle load bypasses the register,
   // and a zero period is clamped to one.
   always_comb begin
      w_period_eff = r_period;
      if (period_load) begin
         w_period_eff = (period_in == '0) ? PERIOD_W'(1) : period_in;
      end
   end

   // Next-state, counter, arbitration and registered-output decisions.
   always_comb begin
      w_state_next    = r_state;
      w_count_next    = r_count;
      w_rr_ptr_next   = r_rr_ptr;
      w_tick_next     = 1'b0;
      w_grant_next    = '0;
      w_grant_id_next = '0;
      case (r_state)
         IDLE: begin
            if (run) begin
               w_state_next = COUNT;
               w_count_next = w_period_eff - PERIOD_W'(1);
            end
         end
         COUNT: begin
            if (r_count == '0) begin
               // Slot boundary: tick and grant are issued even if run just fell.
               w_tick_next  = 1'b1;
               w_count_next = w_period_eff - PERIOD_W'(1);
               if (w_found) begin
                  w_grant_next    = w_onehot;
                  w_grant_id_next = w_idx;
                  w_rr_ptr_next   = w_idx;
               end
               if (!run) begin
                  w_state_next = IDLE;
               end
            end else if (!run) begin
               w_state_next = IDLE;
            end else begin
               w_count_next = r_count - PERIOD_W'(1);
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // State and output registers; reset overrides every other input.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_period   <= PERIOD_W'(1);
         r_rr_ptr   <= ID_W'(N_REQ - 1);
         r_tick     <= 1'b0;
         r_grant    <= '0;
         r_grant_id <= '0;
      end else begin
         r_state    <= w_state_next;
         r_count    <= w_count_next;
         r_period   <= w_period_eff;
         r_rr_ptr   <= w_rr_ptr_next;
         r_tick     <= w_tick_next;
         r_grant    <= w_grant_next;
         r_grant_id <= w_grant_id_next;
      end
   end

   assign tick     = r_tick;
   assign grant    = r_grant;
   assign grant_id = r_grant_id;
   assign busy     = (r_state == COUNT);

endmodule

// File: tb/tb_clock_slot_scheduler.sv
// Self-checking bench for clock_slot_scheduler: vector table, directed
// multi-cycle sequences and a randomized run against a time-based model.
module tb_clock_slot_scheduler;

   localparam int N  = 4;
   localparam int ID = 2;
   localparam int PW = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          run;
   logic [PW-1:0] period_in;
   logic          period_load;
   logic [N-1:0]  req;
   logic          tick;
   logic [N-1:0]  grant;
   logic [ID-1:0] grant_id;
   logic          busy;

   clock_slot_scheduler #(.N_REQ(N), .ID_W(ID), .PERIOD_W(PW)) dut (
      .clock       (clock),
      .reset       (reset),
      .run         (run),
      .period_in   (period_in),
      .period_load (period_load),
      .req         (req),
      .tick        (tick),
      .grant       (grant),
      .grant_id    (grant_id),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: absolute edge time of the next slot boundary.
   bit           m_active = 1'b0;
   int           m_next   = 0;
   int           m_period = 1;
   int           m_last   = N - 1;
   int           m_edge   = 0;
   bit           e_tick;
   logic [N-1:0] e_grant;
   int           e_gid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int p_new;
      m_edge++;
      e_tick  = 1'b0;
      e_grant = '0;
      e_gid   = 0;
      if (reset) begin
         m_active = 1'b0;
         m_period = 1;
         m_last   = N - 1;
      end else begin
         p_new = period_load ? ((period_in == 0) ? 1 : int'(period_in)) : m_period;
         if (!m_active) begin
            if (run) begin
               m_active = 1'b1;
               m_next   = m_edge + p_new;
            end
         end else if (m_edge == m_next) begin
            e_tick = 1'b1;
            for (int k = 1; k <= N; k++) begin
               int i;
               i = (m_last + k) % N;
               if (req[i]) begin
                  e_grant = N'(1) << i;
                  e_gid   = i;
                  m_last  = i;
                  break;
               end
            end
            m_next = m_edge + p_new;
            if (!run) m_active = 1'b0;
         end else if (!run) begin
            m_active = 1'b0;
         end
         m_period = p_new;
      end
   endtask

   // One clock edge: update the model with the inputs sampled there, then compare.
   task automatic cycle();
      @(posedge clock);
      model_step();
      #1;
      chk("m_tick", tick, e_tick);
      chk("m_grant", grant, e_grant);
      chk("m_busy", busy, m_active);
      if (e_grant != '0) chk("m_gid", grant_id, e_gid);
   endtask

   task automatic wait_tick(input int budget, output int n, output logic [N-1:0] g,
                            output logic [ID-1:0] gid);
      n = 0;
      for (int i = 0; i < budget; i++) begin
         cycle();
         n++;
         if (tick) break;
      end
      chk("tick_seen", tick, 1);
      g   = grant;
      gid = grant_id;
   endtask

   typedef struct {
      logic          rst;
      logic          rn;
      logic [PW-1:0] pin;
      logic          pld;
      logic [N-1:0]  rq;
      logic          x_tick;
      logic [N-1:0]  x_grant;
      logic [ID-1:0] x_gid;
      logic          x_busy;
   } vec_t;

   vec_t vecs[18];

   initial begin
      int           n;
      logic [N-1:0] g;
      logic [ID-1:0] gid;

      reset = 1'b1; run = 1'b0; period_in = '0; period_load = 1'b0; req = '0;

      //           rst run pin pld req      tick grant    gid busy
      vecs[0]  = '{1, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 0};
      vecs[1]  = '{0, 1, 0, 0, 4'b1111, 0, 4'b0000, 0, 1};
      vecs[2]  = '{0, 1, 0, 0, 4'b1111, 1, 4'b0001, 0, 1};
      vecs[3]  = '{0, 1, 0, 0, 4'b1111, 1, 4'b0010, 1, 1};
      vecs[4]  = '{0, 1, 0, 0, 4'b1111, 1, 4'b0100, 2, 1};
      vecs[5]  = '{0, 1, 0, 0, 4'b1111, 1, 4'b1000, 3, 1};
      vecs[6]  = '{0, 1, 0, 0, 4'b1111, 1, 4'b0001, 0, 1};
      vecs[7]  = '{0, 1, 0, 0, 4'b0000, 1, 4'b0000, 0, 1};
      vecs[8]  = '{0, 1, 0, 0, 4'b0000, 1, 4'b0000, 0, 1};
      vecs[9]  = '{0, 1, 0, 0, 4'b1000, 1, 4'b1000, 3, 1};
      vecs[10] = '{0, 1, 0, 0, 4'b1111, 1, 4'b0001, 0, 1};
      vecs[11] = '{0, 0, 0, 0, 4'b1111, 1, 4'b0010, 1, 0};
      vecs[12] = '{0, 0, 0, 0, 4'b1111, 0, 4'b0000, 0, 0};
      vecs[13] = '{0, 0, 0, 1, 4'b1111, 0, 4'b0000, 0, 0};
      vecs[14] = '{0, 1, 0, 0, 4'b0100, 0, 4'b0000, 0, 1};
      vecs[15] = '{0, 1, 0, 0, 4'b0100, 1, 4'b0100, 2, 1};
      vecs[16] = '{0, 1, 0, 0, 4'b0100, 1, 4'b0100, 2, 1};
      vecs[17] = '{1, 1, 0, 0, 4'b1111, 0, 4'b0000, 0, 0};

      for (int v = 0; v < 18; v++) begin
         reset = vecs[v].rst; run = vecs[v].rn; period_in = vecs[v].pin;
         period_load = vecs[v].pld; req = vecs[v].rq;
         cycle();
         chk($sformatf("vec%0d_tick", v), tick, vecs[v].x_tick);
         chk($sformatf("vec%0d_grant", v), grant, vecs[v].x_grant);
         chk($sformatf("vec%0d_busy", v), busy, vecs[v].x_busy);
         if (vecs[v].x_grant != '0) chk($sformatf("vec%0d_gid", v), grant_id, vecs[v].x_gid);
         $display("vec %0d: tick=%0b grant=%b gid=%0d busy=%0b", v, tick, grant, grant_id, busy);
      end

      // Period 5 with req 0101: ticks every 5 cycles, grants alternate 0,2.
      reset = 1'b0; run = 1'b0; period_in = 8'd5; period_load = 1'b1; req = 4'b0101;
      cycle();
      period_load = 1'b0; run = 1'b1;
      cycle();
      for (int k = 0; k < 4; k++) begin
         wait_tick(20, n, g, gid);
         chk("p5_gap", n, 5);
         chk("p5_gid", gid, (k % 2 == 1) ? 2 : 0);
         chk("p5_grant", g, (k % 2 == 1) ? 4'b0100 : 4'b0001);
         $display("p5 tick %0d: gap=%0d grant=%b gid=%0d", k, n, g, gid);
      end

      // Period 6, then load 3 mid-count: current slot still 6, later gaps 3.
      run = 1'b0;
      cycle();
      period_in = 8'd6; period_load = 1'b1;
      cycle();
      period_load = 1'b0; run = 1'b1;
      cycle();
      cycle();
      cycle();
      period_in = 8'd3; period_load = 1'b1;
      cycle();
      period_load = 1'b0;
      wait_tick(20, n, g, gid);
      chk("reload_first_gap", n + 3, 6);
      $display("reload: first slot=%0d", n + 3);
      for (int k = 0; k < 2; k++) begin
         wait_tick(20, n, g, gid);
         chk("reload_gap", n, 3);
         $display("reload: gap=%0d", n);
      end

      // Drop run with count=2 at period 4: no tick, idle next cycle; rerun restarts.
      run = 1'b0;
      cycle();
      period_in = 8'd4; period_load = 1'b1;
      cycle();
      period_load = 1'b0; run = 1'b1;
      cycle();
      cycle();
      run = 1'b0;
      cycle();
      chk("drop_tick", tick, 0);
      chk("drop_busy", busy, 0);
      run = 1'b1;
      cycle();
      wait_tick(20, n, g, gid);
      chk("rerun_gap", n, 4);
      $display("drop/rerun: tick=0 busy=0 then gap=%0d", n);

      // Reset in the decision cycle of a slot: outputs clear, period and pointer reset.
      run = 1'b0;
      cycle();
      period_in = 8'd3; period_load = 1'b1; req = 4'b0010;
      cycle();
      period_load = 1'b0; run = 1'b1;
      cycle();
      wait_tick(20, n, g, gid);
      chk("pre_rst_gid", gid, 1);
      cycle();
      cycle();
      reset = 1'b1;
      cycle();
      chk("rst_tick", tick, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0; req = 4'b1111;
      cycle();
      wait_tick(10, n, g, gid);
      chk("post_rst_gap", n, 1);
      chk("post_rst_gid", gid, 0);
      chk("post_rst_grant", g, 4'b0001);
      $display("reset in slot: gap=%0d gid=%0d", n, gid);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         reset       = ($urandom_range(0, 199) == 0);
         run         = ($urandom_range(0, 9) != 0);
         period_load = ($urandom_range(0, 19) == 0);
         period_in   = PW'($urandom_range(0, 6));
         req         = N'($urandom);
         cycle();
      end
      $display("random: %0d cycles done", 3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_slot_scheduler.md
Name: clock_slot_scheduler

Overview:
- Time-division scheduler driven by the system `clock`. A programmable down-counter divides `clock` into periodic slot ticks.
- At each tick, one slot is granted to one of N requesters using round-robin order.
- Sits between the clock source and the units that share a slow-rate resource. Each unit uses its one-cycle `grant` pulse as a clock enable, so the design stays single-clock with no derived clocks.

Parameters:
- N_REQ, 4, number of requesters (power of two, 2..8)
- ID_W, 2, width of the grant index; equals log2(N_REQ)
- PERIOD_W, 8, width of the period register and slot counter

Ports:
- clock  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- run  input  1  level; 1 = scheduler active, 0 = stop
- period_in  input  PERIOD_W  slot period in clock cycles
- period_load  input  1  one-cycle strobe: capture period_in
- req  input  N_REQ  per-requester request level, held until granted
- tick  output  1  one-cycle pulse at each slot boundary
- grant  output  N_REQ  one-hot, one-cycle pulse coincident with tick; all zeros when the slot is unused
- grant_id  output  ID_W  index of the granted requester; valid only while grant is non-zero
- busy  output  1  1 whenever state is not IDLE

Behaviour:
- Reset (reset=1 at a clock edge):
  - state=IDLE; count=0; period_reg=1; rr_ptr=N_REQ-1, so the first search starts at requester 0.
  - tick=0, grant=0, grant_id=0, busy=0.
  - Reset overrides every other input, including mid-count.
- Period register:
  - period_load=1 captures period_in into period_reg.
  - A value of 0 is stored as 1, so period 0 behaves as period 1.
  - A load while running does not alter the current count. It takes effect at the next counter reload.
- States:
  - IDLE: outputs 0. When run=1, go to COUNT and load count=period_reg-1 on that edge.
  - COUNT:
    - If run=0, return to IDLE next cycle with no tick.
    - If count>0, decrement.
    - If count==0, assert tick for exactly one cycle, perform arbitration, reload count=period_reg-1, and stay in COUNT.
- Tick timing:
  - Ticks are spaced exactly period_reg cycles apart.
  - The first tick occurs period_reg cycles after the cycle in which run is first sampled high.
  - With period_reg=1, tick is high every cycle.
- Arbitration, evaluated only in the tick cycle and using req sampled that cycle:
  - Search indices rr_ptr+1, rr_ptr+2, ... modulo N_REQ. The first index with req set wins.
  - The winner gets grant[idx]=1 and grant_id=idx, both registered with tick so they are aligned in the same cycle.
  - After a grant, rr_ptr=idx.
  - If no req is set: tick still pulses, grant=0, and rr_ptr is unchanged.
  - A requester that deasserts req before its slot is simply skipped.
- Simultaneous events:
  - run falling in the tick cycle: tick and grant are still issued, then the block goes to IDLE.
  - period_load in the tick cycle: the reload uses the NEW period value (bypass path).
  - reset asserted together with anything else: reset wins.
- Outputs are registered. No combinational path exists from inputs to outputs.

Decomposition:
- Shared package `clock_sched_pkg`:
  - State encoding constants IDLE=1'b0, COUNT=1'b1.
  - Default parameter constants.
  - A helper function next_rr(req, ptr) returning {found, idx}.
- Natural sub-module `rr_arbiter`:
  - Purely combinational rotating-priority search.
  - Inputs req and ptr; outputs found, idx, onehot.
  - Instantiated once, and reusable by other shared-resource controllers.

Test Plan:
- Reset, then run=1 with the default period 1 and req=4'b1111: tick every cycle; grant_id sequence 0,1,2,3,0.
- Load period_in=5, run=1, req=4'b0101: ticks at cycles 5,10,15,20 after run; grants to 0,2,0,2; grant one-hot and aligned with tick.
- period_in=0 loaded: behaves identically to period 1. Then load 3 mid-count with period 6: the current slot still ends at 6 cycles, and the following gaps are 3.
- req=4'b0000 for two ticks, then req=4'b1000: tick with grant=0 twice, then grant_id=3. rr_ptr is unchanged by empty slots, so the next search after 3 starts at 0.
- run dropped with count=2 (period 4): no tick; busy=0 on the next cycle. Rerun: first tick 4 cycles later.
- reset asserted during the tick cycle: next cycle tick=0, grant=0, busy=0, period_reg=1, and arbitration restarts at requester 0.
